proj2: RTL and testbench

- Sequential modular-exponentiation engine (RSA-style): Cal_val = message_val ^ private_key mod public_key, all operands unsigned 16-bit.
- Top of the encryption datapath. Operands are captured on Start; the block raises a one-cycle Cal_done when the result is valid.
- Uses square-and-multiply. Every multiply is an interleaved shift/add modular multiply, so no intermediate ever exceeds 17 bits.

---
 rtl/proj2_pkg.sv | 6 +
 rtl/proj2_if.sv | 18 +
 rtl/proj2_modmul.sv | 48 ++++
 rtl/proj2.sv | 104 ++++++++++
 tb/tb_proj2.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/proj2_pkg.sv
// proj2_pkg: shared width, multiply length and FSM state encoding for the modexp engine
package proj2_pkg;
    localparam int W = 16;
    localparam int MULT_CYCLES = 16;
    typedef enum logic [2:0] {IDLE, REDUCE, SQR, MUL, DONE} state_t;
endpackage

// File: rtl/proj2_if.sv
// proj2_if: operand/result bundle between requester and engine; Busy exists only with PROJ2_BUSY_OUT_EN
interface proj2_if;
    import proj2_pkg::*;
    logic         Start;
    logic [W-1:0] private_key;
    logic [W-1:0] public_key;
    logic [W-1:0] message_val;
    logic         Cal_done;
    logic [W-1:0] Cal_val;
`ifdef PROJ2_BUSY_OUT_EN
    logic         Busy;
    modport master (output Start, private_key, public_key, message_val, input Cal_done, Cal_val, Busy);
    modport slave (input Start, private_key, public_key, message_val, output Cal_done, Cal_val, Busy);
`else
    modport master (output Start, private_key, public_key, message_val, input Cal_done, Cal_val);
    modport slave (input Start, private_key, public_key, message_val, output Cal_done, Cal_val);
`endif
endinterface

// File: rtl/proj2_modmul.sv
// proj2_modmul: interleaved shift/add x*y mod n over MULT_CYCLES cycles; done flags the final step, p is its result
module proj2_modmul
    import proj2_pkg::*;
(
    input  logic         clk,
    input  logic         Rst,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] p
);
    localparam int CW = $clog2(MULT_CYCLES);
    logic [W-1:0]  p_q, p_d, y_q, y_d, base, ysrc;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d, go;
    logic [W:0]    dbl, dbl_r, add;
    always_comb begin
        go    = run_q | start;
        base  = run_q ? p_q : '0;
        ysrc  = run_q ? y_q : y;
        dbl   = {base, 1'b0};
        dbl_r = dbl >= {1'b0, n} ? dbl - {1'b0, n} : dbl;
        add   = ysrc[W-1] ? dbl_r + {1'b0, x} : dbl_r;
        p_d   = go ? W'(add >= {1'b0, n} ? add - {1'b0, n} : add) : p_q;
        y_d   = go ? {ysrc[W-2:0], 1'b0} : y_q;
        cnt_d = go ? cnt_q + CW'(1) : cnt_q;
        done  = run_q && cnt_q == CW'(MULT_CYCLES - 1);
        run_d = go && !done;
    end
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            p_q   <= '0;
            y_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            y_q   <= y_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end
    assign busy = run_q;
    assign p    = p_d;
endmodule

// File: rtl/proj2.sv
// proj2: square-and-multiply modexp Cal_val = m^e mod n; define PROJ2_BUSY_OUT_EN to add the Busy output
module proj2
    import proj2_pkg::*;
(
    input  logic   clk,
    input  logic   Rst,
    proj2_if.slave bus
);
    localparam int CW = $clog2(W) + 1;
    localparam int IW = $clog2(W);
    state_t        state_q, state_d;
    logic [W-1:0]  e_q, e_d, n_q, n_d, m_q, m_d, b_q, b_d, acc_q, acc_d, val_q, val_d, mm_p;
    logic [IW-1:0] i_q, i_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d, mm_start, mm_busy, mm_done;
    logic [W:0]    rsh;
    proj2_modmul u_mm (
        .clk(clk), .Rst(Rst), .start(mm_start), .x(acc_q), .y(state_q == MUL ? b_q : acc_q),
        .n(n_q), .busy(mm_busy), .done(mm_done), .p(mm_p)
    );
    assign mm_start = (state_q == SQR || state_q == MUL) && !mm_busy;
    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        n_d     = n_q;
        m_d     = m_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        done_d  = 1'b0;
        rsh     = {b_q, m_q[W-1]};
        case (state_q)
            IDLE: if (bus.Start) begin
                e_d     = bus.private_key;
                n_d     = bus.public_key;
                m_d     = bus.message_val;
                b_d     = '0;
                acc_d   = '0;
                i_d     = '0;
                cnt_d   = '0;
                state_d = bus.public_key == '0 ? DONE : REDUCE;
            end
            // W restoring steps leave b = m mod n, then one cycle seeds acc and the bit index
            REDUCE: if (cnt_q == CW'(W)) begin
                acc_d   = W'(n_q != W'(1));
                i_d     = IW'(W - 1);
                cnt_d   = '0;
                state_d = SQR;
            end else begin
                b_d   = W'(rsh >= {1'b0, n_q} ? rsh - {1'b0, n_q} : rsh);
                m_d   = m_q << 1;
                cnt_d = cnt_q + CW'(1);
            end
            SQR: if (mm_done) begin
                acc_d   = mm_p;
                state_d = e_q[i_q] ? MUL : i_q == '0 ? DONE : SQR;
                i_d     = !e_q[i_q] && i_q != '0 ? i_q - IW'(1) : i_q;
            end
            MUL: if (mm_done) begin
                acc_d   = mm_p;
                state_d = i_q == '0 ? DONE : SQR;
                i_d     = i_q == '0 ? i_q : i_q - IW'(1);
            end
            DONE: begin
                val_d   = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            e_q     <= '0;
            n_q     <= '0;
            m_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            cnt_q   <= '0;
            val_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            n_q     <= n_d;
            m_q     <= m_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            done_q  <= done_d;
        end
    end
    assign bus.Cal_done = done_q;
    assign bus.Cal_val  = val_q;
`ifdef PROJ2_BUSY_OUT_EN
    assign bus.Busy = state_q != IDLE;
`endif
endmodule

// File: tb/tb_proj2.sv
// tb_proj2: scoreboard bench for the proj2 modexp engine
module tb_proj2;
    import proj2_pkg::*;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int           total = 0;
    int           bad = 0;
    int           busy_n = 0;
    int           lat = 0;
    logic         seen;
    logic [W-1:0] exp_q[$];

    proj2_if ifc();
    proj2 dut (.clk(clk), .Rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] modexp(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n);
        longint r, b, nn;
        if (n == '0) return '0;
        nn = longint'(n);
        r  = 1 % nn;
        b  = longint'(m) % nn;
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % nn;
            if (e[i]) r = (r * b) % nn;
        end
        return W'(r);
    endfunction

    task automatic send(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n, input bit hold);
        ifc.message_val = m;
        ifc.private_key = e;
        ifc.public_key  = n;
        ifc.Start       = 1'b1;
        exp_q.push_back(modexp(m, e, n));
        @(posedge clk);
        #1;
        busy_n = 0;
`ifdef PROJ2_BUSY_OUT_EN
        busy_n = int'(ifc.Busy);
`endif
        if (!hold) begin
            ifc.Start       = 1'b0;
            ifc.message_val = W'($urandom);
            ifc.private_key = W'($urandom);
            ifc.public_key  = W'($urandom);
        end
    endtask

    task automatic wait_done(input string tag, input bit toggle);
        lat = 0;
        while (lat < 600) begin
            if (toggle && lat < 500) ifc.Start = (lat % 3 == 0);
            @(posedge clk);
            #1;
            lat++;
`ifdef PROJ2_BUSY_OUT_EN
            if (ifc.Busy) busy_n++;
`endif
            if (ifc.Cal_done) break;
        end
        if (toggle) ifc.Start = 1'b0;
        if (!ifc.Cal_done) check({tag, "_timeout"}, 0, 1);
        else if (exp_q.size() == 0) check({tag, "_unexpected"}, 1, 0);
        else check(tag, ifc.Cal_val, exp_q.pop_front());
    endtask

    initial begin
        ifc.Start       = 1'b0;
        ifc.message_val = '0;
        ifc.private_key = '0;
        ifc.public_key  = '0;
        #12;
        check("rst_done", ifc.Cal_done, 0);
        check("rst_val", ifc.Cal_val, 0);
        @(negedge clk);
        rst = 1'b0;

        send(9, 3, 33, 1);
        wait_done("held0", 0);
        exp_q.push_back(modexp(9, 3, 33));
        wait_done("held1", 0);
        exp_q.push_back(modexp(9, 3, 33));
        repeat (100) @(posedge clk);
        #1;
        check("hold_val", ifc.Cal_val, 3);
        wait_done("held2", 0);
        ifc.Start = 1'b0;
        @(posedge clk);
        #1;
        check("pulse_once", ifc.Cal_done, 0);

        send(65, 17, 3233, 0);
        wait_done("rsa_enc", 0);
        send(2790, 2753, 3233, 0);
        wait_done("rsa_dec", 0);
        send(5, 0, 7, 0);
        wait_done("e_zero", 0);
        send(123, 45, 1, 0);
        wait_done("n_one", 0);
        send(77, 9, 0, 0);
        wait_done("n_zero", 0);
        send(0, 5, 11, 0);
        wait_done("m_zero", 0);
        send(40000, 2, 97, 0);
        wait_done("reduce", 0);

        send(65, 17, 3233, 0);
        repeat (100) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_done", ifc.Cal_done, 0);
        check("abort_val", ifc.Cal_val, 0);
`ifdef PROJ2_BUSY_OUT_EN
        check("abort_busy", ifc.Busy, 0);
`endif
        exp_q.delete();
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (600) begin
            @(posedge clk);
            #1;
            seen |= ifc.Cal_done;
        end
        check("late_pulse", seen, 0);
        send(2790, 2753, 3233, 0);
        wait_done("after_abort", 0);

        send(3, 16'hFFFF, 50021, 0);
        wait_done("lat_val", 1);
        check("latency", lat, 530);
`ifdef PROJ2_BUSY_OUT_EN
        check("busy_window", busy_n, 530);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
